// File: rtl/two_bit_shift_register_pkg.sv
// Shared definitions for the universal shift register: mode select type
// and the four mode encodings.
package two_bit_shift_register_pkg;

  typedef logic [1:0] shift_sel_t;

  localparam shift_sel_t SEL_HOLD = 2'b00;
  localparam shift_sel_t SEL_SHL  = 2'b01;
  localparam shift_sel_t SEL_SHR  = 2'b10;
  localparam shift_sel_t SEL_LOAD = 2'b11;

endpackage

// File: rtl/shift_reg_next_mux.sv
// Next-state selection for the universal shift register. Purely combinational.
// With rotate set, the shift modes recirculate the bit falling off the far end
// instead of taking the serial input.
module shift_reg_next_mux
  import two_bit_shift_register_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] cur,
  input  shift_sel_t       sel,
  input  logic [WIDTH-1:0] in,
  input  logic             rightshift,
  input  logic             leftshift,
  input  logic             rotate,
  output logic [WIDTH-1:0] next
);

  logic lsb_fill;
  logic msb_fill;

  // Pick the bit entering at each end for the shift modes
  always_comb begin
    lsb_fill = rotate ? cur[WIDTH-1] : leftshift;
    msb_fill = rotate ? cur[0]       : rightshift;
  end

  // Mode decode; an unknown select falls to the default arm and holds
  always_comb begin
    next = cur;
    case (sel)
      SEL_HOLD: next = cur;
      SEL_SHL:  next = {cur[WIDTH-2:0], lsb_fill};
      SEL_SHR:  next = {msb_fill, cur[WIDTH-1:1]};
      SEL_LOAD: next = in;
      default:  next = cur;
    endcase
  end

endmodule

// File: rtl/two_bit_shift_register.sv
// Universal shift register: hold, shift left, shift right or parallel load
// each clock. Define SHIFT_REG_ROTATE_EN to add the rotate input, which turns
// the shift modes into rotations.
module two_bit_shift_register
  import two_bit_shift_register_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  shift_sel_t       sel,
  input  logic [WIDTH-1:0] in,
  input  logic             rightshift,
  input  logic             leftshift,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] next;
  logic             rotate_eff;

`ifdef SHIFT_REG_ROTATE_EN
  assign rotate_eff = rotate;
`else
  assign rotate_eff = 1'b0;
`endif

  shift_reg_next_mux #(.WIDTH(WIDTH)) u_next_mux (
    .cur        (out),
    .sel        (sel),
    .in         (in),
    .rightshift (rightshift),
    .leftshift  (leftshift),
    .rotate     (rotate_eff),
    .next       (next)
  );

  // Flop bank, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out <= '0;
    else          out <= next;
  end

endmodule

// File: tb/tb_two_bit_shift_register.sv
// Self-checking bench for two_bit_shift_register: directed scenarios with
// literal expectations, then randomized traffic with async reset pulses,
// all checked every cycle against an arithmetic reference model.
module tb_two_bit_shift_register;

  localparam int W = 2;
`ifdef SHIFT_REG_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   sel = 2'b00;
  logic [W-1:0] in_d = '0;
  logic         rs = 1'b0;
  logic         ls = 1'b0;
  logic         rot = 1'b0;
  logic [W-1:0] out_q;

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] model = '0;
  bit           check_en = 1'b0;

  always #5 clk = ~clk;

  two_bit_shift_register #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sel        (sel),
    .in         (in_d),
    .rightshift (rs),
`ifdef SHIFT_REG_ROTATE_EN
    .rotate     (rot),
`endif
    .leftshift  (ls),
    .out        (out_q)
  );

  // Reference: value after one edge, using integer shifts and masks
  function automatic logic [W-1:0] predict(input logic [W-1:0] cur, input logic [1:0] s,
                                           input logic [W-1:0] d, input logic r,
                                           input logic l, input logic ro);
    int unsigned v;
    int unsigned mask;
    int unsigned fill;
    v    = int'(cur);
    mask = (1 << W) - 1;
    case (s)
      2'd1: begin
        fill = (ROT && ro) ? ((v >> (W - 1)) & 1) : int'(l);
        v    = ((v << 1) & mask) | fill;
      end
      2'd2: begin
        fill = (ROT && ro) ? (v & 1) : int'(r);
        v    = (v >> 1) | (fill << (W - 1));
      end
      2'd3: v = int'(d);
      default: v = int'(cur);
    endcase
    return v[W-1:0];
  endfunction

  always @(posedge clk) begin
    if (reset_n) model = predict(model, sel, in_d, rs, ls, rot);
  end

  always @(negedge reset_n) model = '0;

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (check_en) begin
      total++;
      if (out_q !== model) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t out=%b model=%b", $time, out_q, model);
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] exp);
    total++;
    if (out_q !== exp || model !== exp) begin
      bad++;
      $display("FAIL %s out=%b model=%b expected=%b", name, out_q, model, exp);
    end
  endtask

  task automatic apply(input logic [1:0] s, input logic [W-1:0] d, input logic r,
                       input logic l, input logic ro);
    @(negedge clk);
    #1;
    sel = s; in_d = d; rs = r; ls = l; rot = ro;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 chk("reset_initial", 2'b00);
    reset_n = 1'b1;
    check_en = 1'b1;

    // Reset arriving mid-cycle clears without a clock
    apply(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("load_11", 2'b11);
    #2 reset_n = 1'b0;
    #1 chk("reset_async", 2'b00);
    @(posedge clk);
    #1 chk("reset_hold", 2'b00);
    @(negedge clk);
    #1 reset_n = 1'b1;

    apply(2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
    chk("load_10", 2'b10);

    apply(2'b10, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("shr_in1", 2'b11);
    apply(2'b10, 2'b01, 1'b0, 1'b1, 1'b0);
    chk("shr_in0", 2'b01);

    apply(2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
    apply(2'b01, 2'b11, 1'b0, 1'b1, 1'b0);
    chk("shl_in1", 2'b01);
    apply(2'b01, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("shl_in0", 2'b10);

    apply(2'b00, 2'b01, 1'b1, 1'b1, 1'b0);
    chk("hold_1", 2'b10);
    apply(2'b00, 2'b11, 1'b0, 1'b0, 1'b1);
    chk("hold_2", 2'b10);
    apply(2'b00, 2'b00, 1'b1, 1'b1, 1'b1);
    chk("hold_3", 2'b10);

`ifdef SHIFT_REG_ROTATE_EN
    apply(2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
    apply(2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("rot_right", 2'b01);
    apply(2'b01, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("rot_left", 2'b10);
    apply(2'b10, 2'b00, 1'b1, 1'b1, 1'b1);
    chk("rot_right_ign", 2'b01);
`else
    apply(2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
    apply(2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("norot_right", 2'b01);
    apply(2'b01, 2'b00, 1'b0, 1'b1, 1'b1);
    chk("norot_left", 2'b11);
`endif

    // Randomized traffic with occasional short reset pulses
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      sel  = 2'($urandom_range(3));
      in_d = W'($urandom);
      rs   = 1'($urandom);
      ls   = 1'($urandom);
      rot  = 1'($urandom);
      if ($urandom_range(39) == 0) begin
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      @(posedge clk);
    end

    @(negedge clk);
    #1 check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
